// File: rtl/gate_tt_scanner.sv
// Self-check sequencer for a small combinational gate: walks every input vector,
// captures the gate output into a truth table and counts mismatches against EXPECTED.
module gate_tt_scanner #(
    parameter int                       N_IN     = 2,
    parameter int                       SETTLE   = 1,
    parameter logic [(1 << N_IN) - 1:0] EXPECTED = 4'b0111
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    output logic [N_IN-1:0]            gut_in,
    input  logic                       gut_y,
    output logic                       busy,
    output logic                       done,
    output logic [(1 << N_IN) - 1:0]   tt,
    output logic [N_IN:0]              err_cnt,
    output logic                       pass,
    output logic [1:0]                 fsm_state
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [N_IN-1:0] idx;
    logic [CW-1:0]   cnt;
    logic            last_vec;
    logic            settled;
    logic            mismatch;
    logic            aborting;

    assign last_vec  = &idx;
    assign settled   = (cnt == CW'(SETTLE - 1));
    assign mismatch  = (gut_y != EXPECTED[idx]);
    assign aborting  = abort && (state == S_DRIVE || state == S_SAMPLE);
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_DRIVE;
            end
            S_DRIVE: begin
                if (abort)        state_next = S_IDLE;
                else if (settled) state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)         state_next = S_IDLE;
                else if (last_vec) state_next = S_DONE;
                else               state_next = S_DRIVE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gut_in  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            tt      <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
            idx     <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (aborting) begin
                // Partial tt/err_cnt stay visible; the in-flight sample is dropped.
                gut_in <= '0;
                busy   <= 1'b0;
                pass   <= 1'b0;
                idx    <= '0;
                cnt    <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            gut_in  <= '0;
                            busy    <= 1'b1;
                            tt      <= '0;
                            err_cnt <= '0;
                            pass    <= 1'b0;
                            idx     <= '0;
                            cnt     <= '0;
                        end
                    end
                    S_DRIVE: begin
                        if (!settled) cnt <= cnt + CW'(1);
                    end
                    S_SAMPLE: begin
                        tt[idx] <= gut_y;
                        if (mismatch) err_cnt <= err_cnt + (N_IN + 1)'(1);
                        if (last_vec) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            // Fold in the final vector so pass is valid with the done pulse.
                            pass <= (err_cnt == '0) && !mismatch;
                        end else begin
                            idx    <= idx + N_IN'(1);
                            gut_in <= idx + N_IN'(1);
                            cnt    <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gate_tt_scanner.sv
// Bench for gate_tt_scanner: table of GUT models run through full scans, plus
// SETTLE=3 timing, abort and asynchronous reset sequences.
module tb_gate_tt_scanner;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [1:0] gut_in;
    logic       gut_y;
    logic       busy;
    logic       done;
    logic [3:0] tt;
    logic [2:0] err_cnt;
    logic       pass;
    logic [1:0] fsm_state;

    logic       start3;
    logic       abort3;
    logic [1:0] gut_in3;
    logic       gut_y3;
    logic       busy3;
    logic       done3;
    logic [3:0] tt3;
    logic [2:0] err_cnt3;
    logic       pass3;
    logic [1:0] fsm_state3;

    int mode;
    int checks;
    int failures;

    logic [7:0] exp_q[$];
    logic [7:0] exp3_q[$];

    typedef struct {
        int         mode;
        logic [3:0] tt;
        logic [2:0] err;
        logic       pass;
    } vec_t;

    vec_t vecs[5];

    gate_tt_scanner #(.N_IN(2), .SETTLE(1), .EXPECTED(4'b0111)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .gut_in(gut_in), .gut_y(gut_y), .busy(busy), .done(done),
        .tt(tt), .err_cnt(err_cnt), .pass(pass), .fsm_state(fsm_state)
    );

    gate_tt_scanner #(.N_IN(2), .SETTLE(3), .EXPECTED(4'b0111)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3),
        .gut_in(gut_in3), .gut_y(gut_y3), .busy(busy3), .done(done3),
        .tt(tt3), .err_cnt(err_cnt3), .pass(pass3), .fsm_state(fsm_state3)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // GUT models: 0 NAND, 1 AND, 2 stuck-1, 3 XOR, 4 stuck-0
    always_comb begin
        gut_y = 1'b0;
        case (mode)
            0: gut_y = ~(gut_in[1] & gut_in[0]);
            1: gut_y = gut_in[1] & gut_in[0];
            2: gut_y = 1'b1;
            3: gut_y = gut_in[1] ^ gut_in[0];
            default: gut_y = 1'b0;
        endcase
    end
    assign gut_y3 = ~(gut_in3[1] & gut_in3[0]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboards: results pushed at start, popped on each done pulse
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [7:0] r;
                r = exp_q.pop_front();
                check("result_tt", {28'd0, tt}, {28'd0, r[7:4]});
                check("result_err_cnt", {29'd0, err_cnt}, {29'd0, r[3:1]});
                check("result_pass", {31'd0, pass}, {31'd0, r[0]});
            end
        end
        if (done3) begin
            if (exp3_q.size() == 0) begin
                check("unexpected_done3", 32'd1, 32'd0);
            end else begin
                logic [7:0] r;
                r = exp3_q.pop_front();
                check("result3_tt", {28'd0, tt3}, {28'd0, r[7:4]});
                check("result3_err_cnt", {29'd0, err_cnt3}, {29'd0, r[3:1]});
                check("result3_pass", {31'd0, pass3}, {31'd0, r[0]});
            end
        end
    end

    // Driver: full SETTLE=1 scan, checking vector sequence and done timing
    task automatic scan1(input logic [3:0] e_tt, input logic [2:0] e_err, input logic e_pass,
                         input logic with_abort);
        exp_q.push_back({e_tt, e_err, e_pass});
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check("seq_gut_in", {30'd0, gut_in}, j / 2);
            check("seq_busy", {31'd0, busy}, 32'd1);
            check("seq_done_low", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mode     = 0;
        start    = 1'b0;
        abort    = 1'b0;
        start3   = 1'b0;
        abort3   = 1'b0;

        vecs[0] = '{0, 4'b0111, 3'd0, 1'b1};
        vecs[1] = '{1, 4'b1000, 3'd4, 1'b0};
        vecs[2] = '{2, 4'b1111, 3'd1, 1'b0};
        vecs[3] = '{3, 4'b0110, 3'd1, 1'b0};
        vecs[4] = '{4, 4'b0000, 3'd3, 1'b0};

        rst = 1'b1;
        #3;
        check("rst_gut_in", {30'd0, gut_in}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_tt", {28'd0, tt}, 32'd0);
        check("rst_err_cnt", {29'd0, err_cnt}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_state", {30'd0, fsm_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_busy", {31'd0, busy}, 32'd0);

        // Table-driven scans over the GUT models
        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].mode;
            scan1(vecs[i].tt, vecs[i].err, vecs[i].pass, 1'b0);
            repeat (2) @(negedge clk);
            check("idle_hold_tt", {28'd0, tt}, {28'd0, vecs[i].tt});
            check("idle_hold_err", {29'd0, err_cnt}, {29'd0, vecs[i].err});
            check("idle_hold_pass", {31'd0, pass}, {31'd0, vecs[i].pass});
        end

        // SETTLE=3: 4 cycles per vector, extra start at cycle 5 ignored
        exp3_q.push_back({4'b0111, 3'd0, 1'b1});
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int j = 0; j < 16; j++) begin
            start3 = (j == 5);
            check("s3_gut_in", {30'd0, gut_in3}, j / 4);
            check("s3_busy", {31'd0, busy3}, 32'd1);
            check("s3_done_low", {31'd0, done3}, 32'd0);
            @(negedge clk);
        end
        start3 = 1'b0;
        check("s3_done_pulse", {31'd0, done3}, 32'd1);
        @(negedge clk);
        check("s3_done_one_cycle", {31'd0, done3}, 32'd0);

        // Abort in SAMPLE of vector 2 (cycle 5 after acceptance)
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_pre_gut_in", {30'd0, gut_in}, 32'd2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_gut_in", {30'd0, gut_in}, 32'd0);
        check("abort_pass", {31'd0, pass}, 32'd0);
        check("abort_tt", {28'd0, tt}, 32'h3);
        check("abort_err_cnt", {29'd0, err_cnt}, 32'd0);
        check("abort_no_done", {31'd0, done}, 32'd0);
        repeat (10) @(negedge clk);
        check("abort_stays_idle", {30'd0, fsm_state}, 32'd0);
        // Restart with start and abort together: start wins
        scan1(4'b0111, 3'd0, 1'b1, 1'b1);

        // Asynchronous reset during DRIVE of vector 1
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("prerst_gut_in", {30'd0, gut_in}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_gut_in", {30'd0, gut_in}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_tt", {28'd0, tt}, 32'd0);
        check("arst_err_cnt", {29'd0, err_cnt}, 32'd0);
        check("arst_pass", {31'd0, pass}, 32'd0);
        check("arst_state", {30'd0, fsm_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("postrst_idle", {30'd0, fsm_state}, 32'd0);
        check("postrst_busy", {31'd0, busy}, 32'd0);
        check("postrst_gut_in", {30'd0, gut_in}, 32'd0);

        check("missing_done", exp_q.size(), 32'd0);
        check("missing_done3", exp3_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
